// File: rtl/aes_input_loader.sv
// rtl/aes_input_loader.sv - byte-stream to 128-bit key/plaintext block loader
// Optional AES_LOADER_KEY_REUSE_EN: retain the key across blocks unless key_reload is set.
module aes_input_loader #(
  parameter int unsigned FIRST_BYTE_MSB = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] key,
  output logic [127:0] plain_text,
  output logic         blk_valid,
`ifdef AES_LOADER_KEY_REUSE_EN
  input  logic         key_reload,
`endif
  input  logic         blk_ready
);

  typedef enum logic [1:0] {S_KEY, S_PT, S_OUT} state_e;

  localparam logic [3:0] LAST_BYTE = 4'd15;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   pt_q, pt_d;
  logic           blk_valid_q, blk_valid_d;
  logic           in_ready_q, in_ready_d;
  logic           accept;
  logic           handshake;

  // First byte of a word drifts to the top (MSB mode) or bottom (LSB mode) after 16 shifts.
  function automatic logic [127:0] shift_in(input logic [127:0] cur, input logic [7:0] b);
    if (FIRST_BYTE_MSB != 0) return {cur[119:0], b};
    else                     return {b, cur[127:8]};
  endfunction

  assign accept    = in_valid && in_ready_q;
  assign handshake = blk_valid_q && blk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_KEY;
      cnt_q       <= 4'd0;
      key_q       <= 128'd0;
      pt_q        <= 128'd0;
      blk_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      blk_valid_q <= blk_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_KEY;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_KEY: if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_BYTE) state_d = S_PT;
        end
        S_PT: if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_BYTE) state_d = S_OUT;
        end
        S_OUT: if (handshake) begin
          cnt_d = 4'd0;
`ifdef AES_LOADER_KEY_REUSE_EN
          state_d = key_reload ? S_KEY : S_PT;
`else
          state_d = S_KEY;
`endif
        end
        default: begin
          state_d = S_KEY;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    key_d = key_q;
    pt_d  = pt_q;
    if (!flush && accept) begin
      if (state_q == S_KEY)     key_d = shift_in(key_q, in_data);
      else if (state_q == S_PT) pt_d  = shift_in(pt_q, in_data);
    end
    blk_valid_d = (state_d == S_OUT);
    in_ready_d  = (state_d != S_OUT);
  end

  assign in_ready   = in_ready_q;
  assign key        = key_q;
  assign plain_text = pt_q;
  assign blk_valid  = blk_valid_q;

endmodule
